modulo_n_down_timer: RTL and testbench

- Programmable modulo-N down-counting timer with a start/stop control FSM.
- Counts a latched period down to zero and emits a one-cycle terminal-count pulse.
- Runs either auto-reload (periodic tick) or one-shot (single timeout with sticky done).
- Complements the team's up-counting modulo-N counter: it is the countdown/timeout side used by control logic that needs periodic ticks or single timeouts.

---
 rtl/modulo_n_down_timer.sv | 135 +++++++++++++
 tb/tb_modulo_n_down_timer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/modulo_n_down_timer.sv
`default_nettype none
// ============================================================================
//  Module      : modulo_n_down_timer
//  Description : Programmable modulo-N down-counting timer with a start/stop
//                control FSM. A period P (load_val, or N when load_val is 0)
//                is latched on an accepted start. The count runs from P-1 down
//                to 0 on enabled cycles. Reaching 0 produces a one-cycle
//                terminal-count pulse and then either reloads (auto-reload)
//                or parks in DONE (one-shot).
//
//  Ports       : clk          rising-edge clock
//                reset        synchronous active-high reset
//                start        start / restart request (level, sampled)
//                stop         abort; has priority over start
//                enable       count-advance qualifier while running
//                auto_reload  1 = periodic, 0 = one-shot (latched on start)
//                load_val     period P, 0 selects N (latched on start)
//                count_out    remaining count (registered)
//                tc_pulse     one-cycle terminal-count pulse (registered)
//                busy         high while running
//                done         high after a one-shot run has completed
//
//  Revision    : 1.0 - initial release
// ============================================================================
module modulo_n_down_timer #(
    parameter int N         = 10,
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 enable,
    input  logic                 auto_reload,
    input  logic [CNT_WIDTH-1:0] load_val,
    output logic [CNT_WIDTH-1:0] count_out,
    output logic                 tc_pulse,
    output logic                 busy,
    output logic                 done
);

    // N may equal 2^CNT_WIDTH, so N-1 is formed in integer arithmetic and
    // then narrowed; it always fits in CNT_WIDTH bits.
    localparam logic [CNT_WIDTH-1:0] c_N_M1 = CNT_WIDTH'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [CNT_WIDTH-1:0]   r_count;
    logic [CNT_WIDTH-1:0]   r_reload;   // latched P-1
    logic                   r_auto;     // latched mode
    logic                   r_tc;
    logic                   r_busy;
    logic                   r_done;

    logic [CNT_WIDTH-1:0]   w_start_reload;
    logic                   w_at_zero;

    // load_val of 0 selects the default period; otherwise load_val-1 cannot
    // underflow because load_val is at least 1.
    assign w_start_reload = (load_val == '0) ? c_N_M1 : (load_val - 1'b1);
    assign w_at_zero      = (r_count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_auto   <= 1'b0;
            r_tc     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (stop) begin
            // Abort from any state, even with start asserted in the same cycle.
            r_state <= S_IDLE;
            r_count <= '0;
            r_tc    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (start) begin
            // Start or restart: a restart in RUN reloads without a tc pulse.
            r_state  <= S_RUN;
            r_count  <= w_start_reload;
            r_reload <= w_start_reload;
            r_auto   <= auto_reload;
            r_tc     <= 1'b0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (!enable) begin
                        r_tc <= 1'b0;
                    end else if (!w_at_zero) begin
                        r_count <= r_count - 1'b1;
                        r_tc    <= 1'b0;
                    end else begin
                        // Terminal count: pulse, then reload or finish.
                        r_tc <= 1'b1;
                        if (r_auto) begin
                            r_count <= r_reload;
                        end else begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_tc   <= 1'b0;
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_count <= '0;
                    r_tc    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign count_out = r_count;
    assign tc_pulse  = r_tc;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_modulo_n_down_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_modulo_n_down_timer
//  Description : Self-checking bench for modulo_n_down_timer. A reference
//                model tracks the run as "enabled cycles since start" and
//                derives the count arithmetically; directed sequences add
//                hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_modulo_n_down_timer;

    localparam int N         = 10;
    localparam int CNT_WIDTH = 4;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic                 stop = 1'b0;
    logic                 enable = 1'b0;
    logic                 auto_reload = 1'b0;
    logic [CNT_WIDTH-1:0] load_val = '0;
    logic [CNT_WIDTH-1:0] count_out;
    logic                 tc_pulse;
    logic                 busy;
    logic                 done;

    int total = 0;
    int bad   = 0;

    modulo_n_down_timer #(.N(N), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .enable      (enable),
        .auto_reload (auto_reload),
        .load_val    (load_val),
        .count_out   (count_out),
        .tc_pulse    (tc_pulse),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a run is described by its period, its mode and the
    // number of enabled cycles k since the start; the remaining count is
    // P-1 - (k mod P), and a terminal count happens on every P-th enabled cycle.
    bit m_run  = 0;
    bit m_done = 0;
    bit m_tc   = 0;
    bit m_auto = 0;
    int m_p    = 1;
    int m_k    = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_run = 0; m_done = 0; m_tc = 0; m_k = 0;
        end else if (stop) begin
            m_run = 0; m_done = 0; m_tc = 0;
        end else if (start) begin
            m_run  = 1;
            m_done = 0;
            m_tc   = 0;
            m_k    = 0;
            m_p    = (load_val == 0) ? N : int'(load_val);
            m_auto = auto_reload;
        end else if (m_run && enable) begin
            m_tc = ((m_k % m_p) == m_p - 1);
            m_k++;
            if (!m_auto && m_k == m_p) begin
                m_run  = 0;
                m_done = 1;
            end
        end else begin
            m_tc = 0;
        end
        #1;
        check("model_count", int'(count_out), m_run ? (m_p - 1 - (m_k % m_p)) : 0);
        check("model_tc",    int'(tc_pulse),  int'(m_tc));
        check("model_busy",  int'(busy),      int'(m_run));
        check("model_done",  int'(done),      int'(m_done));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic lit(input string nm, input int c, input int t, input int b, input int d);
        check({nm, "_count"}, int'(count_out), c);
        check({nm, "_tc"},    int'(tc_pulse),  t);
        check({nm, "_busy"},  int'(busy),      b);
        check({nm, "_done"},  int'(done),      d);
    endtask

    task automatic pulse_start(input logic [CNT_WIDTH-1:0] lv, input logic ar);
        load_val    = lv;
        auto_reload = ar;
        start       = 1'b1;
        cyc(1);
        start       = 1'b0;
    endtask

    initial begin
        cyc(2);
        lit("reset", 0, 0, 0, 0);
        reset = 1'b0;
        enable = 1'b1;
        cyc(2);
        lit("idle_enable_ignored", 0, 0, 0, 0);

        // 1: default period, periodic
        pulse_start('0, 1'b1);
        lit("t1_first", 9, 0, 1, 0);
        load_val = 4'd3;             // mid-run change must not matter
        auto_reload = 1'b0;
        cyc(9);
        lit("t1_zero", 0, 0, 1, 0);
        cyc(1);
        lit("t1_reload", 9, 1, 1, 0);
        cyc(1);
        lit("t1_after_tc", 8, 0, 1, 0);
        cyc(12);

        // 2: one-shot of 3
        pulse_start(4'd3, 1'b0);
        lit("t2_first", 2, 0, 1, 0);
        cyc(2);
        lit("t2_zero", 0, 0, 1, 0);
        cyc(1);
        lit("t2_tc_done", 0, 1, 0, 1);
        cyc(3);
        lit("t2_done_held", 0, 0, 0, 1);
        pulse_start(4'd3, 1'b0);
        lit("t2_restart", 2, 0, 1, 0);
        cyc(5);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        lit("t2_stop_from_done", 0, 0, 0, 0);

        // 3: period 5 with enable toggling
        pulse_start(4'd5, 1'b1);
        for (int i = 0; i < 24; i++) begin
            enable = (i % 2 == 0);
            cyc(1);
        end
        enable = 1'b1;

        // 4: start+stop together, then restarts
        pulse_start(4'd5, 1'b1);
        cyc(2);
        lit("t4_at2", 2, 0, 1, 0);
        start = 1'b1; stop = 1'b1;
        cyc(1);
        start = 1'b0; stop = 1'b0;
        lit("t4_startstop", 0, 0, 0, 0);
        pulse_start(4'd5, 1'b1);
        cyc(2);
        pulse_start(4'd5, 1'b1);
        lit("t4_restart_run", 4, 0, 1, 0);
        cyc(3);

        // 5: reset mid-run at count 1
        pulse_start(4'd4, 1'b1);
        cyc(2);
        lit("t5_at1", 1, 0, 1, 0);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        lit("t5_reset", 0, 0, 0, 0);
        cyc(3);
        lit("t5_stays_idle", 0, 0, 0, 0);

        // 6: period 1 periodic
        pulse_start(4'd1, 1'b1);
        lit("t6_first", 0, 0, 1, 0);
        cyc(1);
        lit("t6_tc1", 0, 1, 1, 0);
        cyc(1);
        lit("t6_tc2", 0, 1, 1, 0);
        enable = 1'b0;
        cyc(1);
        lit("t6_disabled", 0, 0, 1, 0);
        enable = 1'b1;
        cyc(3);

        // N: one-shot with default period runs 10 enabled cycles
        pulse_start('0, 1'b0);
        cyc(10);
        lit("n_oneshot_done", 0, 1, 0, 1);
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
